// File: rtl/alsu_adder_arbiter_if.sv
// Bus bundle between the ALSU issue logic, the adder arbiter and the adder top.
// slave = arbiter side, master = environment (requesters, adder, consumer).
interface alsu_adder_arbiter_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned SEL_W  = 5
);
    logic              r0_valid;
    logic              r0_ready;
    logic [DATA_W-1:0] r0_a;
    logic [DATA_W-1:0] r0_b;
    logic [SEL_W-1:0]  r0_sel;

    logic              r1_valid;
    logic              r1_ready;
    logic [DATA_W-1:0] r1_a;
    logic [DATA_W-1:0] r1_b;
    logic [SEL_W-1:0]  r1_sel;

    logic [DATA_W-1:0] adder_a;
    logic [DATA_W-1:0] adder_b;
    logic [SEL_W-1:0]  adder_sel;
    logic [DATA_W-1:0] adder_sum;
    logic              adder_cout;
    logic              adder_neg;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_sum;
    logic              rsp_cout;
    logic              rsp_neg;

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_sel,
        output r0_ready,
        input  r1_valid, r1_a, r1_b, r1_sel,
        output r1_ready,
        output adder_a, adder_b, adder_sel,
        input  adder_sum, adder_cout, adder_neg,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_neg,
        input  rsp_ready
    );

    modport master (
        output r0_valid, r0_a, r0_b, r0_sel,
        input  r0_ready,
        output r1_valid, r1_a, r1_b, r1_sel,
        input  r1_ready,
        input  adder_a, adder_b, adder_sel,
        output adder_sum, adder_cout, adder_neg,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_neg,
        output rsp_ready
    );
endinterface

// File: rtl/alsu_adder_arbiter.sv
// Two-requester arbiter for the shared ALSU adder. One operation in flight at a
// time: IDLE (grant) -> EXEC (adder settles) -> RESP (hold result until taken).
module alsu_adder_arbiter #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned SEL_W      = 5,
    parameter bit          PRIO_FIXED = 1'b0
) (
    input logic                 clk,
    input logic                 rst_n,
    alsu_adder_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_ptr;       // 1 = r1 wins a tie (round-robin mode)
    logic              r_id;        // requester owning the in-flight operation
    logic              w_win1;      // r1 is the current winner
    logic              w_hs;        // handshake with the winner this cycle
    logic [DATA_W-1:0] w_win_a;
    logic [DATA_W-1:0] w_win_b;
    logic [SEL_W-1:0]  w_win_sel;

    // Winner selection and handshake qualification
    always_comb begin
        w_win1    = bus.r1_valid & (~bus.r0_valid | ((PRIO_FIXED == 1'b0) & r_ptr));
        w_win_a   = w_win1 ? bus.r1_a   : bus.r0_a;
        w_win_b   = w_win1 ? bus.r1_b   : bus.r0_b;
        w_win_sel = w_win1 ? bus.r1_sel : bus.r0_sel;
        // ready is gated by rst_n so nothing is accepted in a reset cycle
        w_hs      = rst_n & (r_state == S_IDLE) & (bus.r0_valid | bus.r1_valid);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Combinational ready outputs: only the winner, only in IDLE
    always_comb begin
        bus.r0_ready = w_hs & ~w_win1;
        bus.r1_ready = w_hs & w_win1;
    end

    // Operand latch, pointer update and response capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr         <= 1'b0;
            r_id          <= 1'b0;
            bus.adder_a   <= '0;
            bus.adder_b   <= '0;
            bus.adder_sel <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
            bus.rsp_neg   <= 1'b0;
        end else begin
            if (w_hs) begin
                bus.adder_a   <= w_win_a;
                bus.adder_b   <= w_win_b;
                bus.adder_sel <= w_win_sel;
                r_id          <= w_win1;
                r_ptr         <= ~w_win1;
            end
            if (r_state == S_EXEC) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_id    <= r_id;
                bus.rsp_sum   <= bus.adder_sum;
                bus.rsp_cout  <= bus.adder_cout;
                bus.rsp_neg   <= bus.adder_neg;
            end
            if ((r_state == S_RESP) && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule
